// File: rtl/muldiv.sv
// Iterative 32-bit MIPS multiply/divide unit with architectural HI/LO.
// One shift-add or restoring shift-subtract step per cycle, n steps per operation.
module muldiv #(
  parameter int n  = 32,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         mthi,
  input  logic         mtlo,
  input  logic [n-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] hi,
  output logic [n-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(n - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            isdiv, sa, sb, dz;
  logic [n-1:0]    mb;   // divisor / multiplicand magnitude
  logic [n-1:0]    acc;  // partial remainder / product upper half
  logic [n-1:0]    q;    // dividend->quotient / multiplier->product lower half

  logic            sgn;
  logic [n-1:0]    amag, bmag;
  logic [n:0]      sum, shl;
  logic [n-1:0]    diff, nacc, nq, rhi, rlo;
  logic [2*n-1:0]  prod;

  always_comb begin
    sgn  = ~op[0];
    amag = (sgn & a[n-1]) ? -a : a;
    bmag = (sgn & b[n-1]) ? -b : b;

    sum  = {1'b0, acc} + {1'b0, mb};
    shl  = {acc, q[n-1]};
    diff = shl[n-1:0] - mb;
    nacc = acc;
    nq   = q;
    if (!isdiv) begin
      if (q[0]) {nacc, nq} = {sum, q[n-1:1]};
      else      {nacc, nq} = {1'b0, acc, q[n-1:1]};
    end else if (shl >= {1'b0, mb}) begin
      nacc = diff;
      nq   = {q[n-2:0], 1'b1};
    end else begin
      nacc = shl[n-1:0];
      nq   = {q[n-2:0], 1'b0};
    end

    prod = {nacc, nq};
    if (sa ^ sb) prod = -prod;

    // Divide by zero falls out naturally as q=all ones, rem=|a|; sign fixup restores a.
    if (!isdiv) begin
      {rhi, rlo} = prod;
    end else begin
      rhi = sa ? -nacc : nacc;
      rlo = dz ? '1 : ((sa ^ sb) ? -nq : nq);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      isdiv <= 1'b0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      dz    <= 1'b0;
      mb    <= '0;
      acc   <= '0;
      q     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            isdiv <= op[1];
            sa    <= sgn & a[n-1];
            sb    <= sgn & b[n-1];
            dz    <= (b == '0);
            mb    <= bmag;
            q     <= amag;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        S_RUN: begin
          acc <= nacc;
          q   <= nq;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            hi    <= rhi;
            lo    <= rlo;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv.md
Name: muldiv

Overview:
- Iterative 32-bit multiply/divide unit for the EX stage. It sits beside the ALU and consumes the same A/B operands from the ID/EX register.
- Implements MIPS MULT, MULTU, DIV and DIVU into architectural HI/LO registers, plus MTHI/MTLO writes. MFHI/MFLO read `hi`/`lo` directly.
- Hazard logic stalls the pipeline while `busy` is high.

Parameters:
- `n`, default 32: operand, HI and LO width.
- `CW`, default 6: iteration counter width. Must satisfy 2^CW > n.

Ports:
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset (0 = reset).
- `start`  input  1  launch operation; sampled only in IDLE.
- `op`  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  input  n  rs operand (multiplicand / dividend).
- `b`  input  n  rt operand (multiplier / divisor).
- `mthi`  input  1  write `wdata` to HI.
- `mtlo`  input  1  write `wdata` to LO.
- `wdata`  input  n  MTHI/MTLO data.
- `busy`  output  1  operation in progress; pipeline stall request.
- `done`  output  1  one-cycle pulse; HI/LO hold the new result.
- `hi`  output  n  HI register (product upper half / remainder).
- `lo`  output  n  LO register (product lower half / quotient).

Behaviour:

Reset:
- `reset`=0 asynchronously forces state IDLE, counter 0, and `busy`=0, `done`=0, `hi`=0, `lo`=0.
- Reset mid-operation aborts the operation. No partial result is ever written.

States:
- IDLE:
  - `start`=1 latches `op`, magnitudes of `a`/`b` (signed ops only), the sign flags, and a divide-by-zero flag (`b`==0). Clears the counter and goes to RUN.
  - `start`=0: stay in IDLE.
- RUN:
  - One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
  - After n steps, go to DONE.
- DONE:
  - Writes signed-corrected results to HI/LO on entry.
  - `done`=1 for exactly that one cycle, then return to IDLE unconditionally.

Timing:
- `busy` is registered. It is 1 for exactly n cycles (RUN) after the accepting edge, and 0 in IDLE and DONE.
- Latency: `start` accepted at edge 0 gives `busy` high in cycles 1..n, `done` high in cycle n+1, and new `hi`/`lo` visible in cycle n+1.
- `start` while not in IDLE is ignored (no queueing).
- `a`, `b` and `op` need only be valid in the accepting cycle.

Arithmetic:
- MULTU: {hi,lo} = a*b, 2n-bit unsigned.
- MULT: unsigned product of magnitudes, 2n-bit negated if sign(a) != sign(b).
- DIVU: lo = a/b, hi = a%b.
- DIV:
  - Quotient negated if signs differ.
  - Remainder takes the sign of the dividend.
  - -2^31 / -1 gives lo=0x80000000, hi=0 (natural wrap, no trap).
- Divide by zero (DIV or DIVU):
  - lo = all ones, hi = original `a`.
  - Same n+1 latency.
- No overflow or exception output.

MTHI/MTLO:
- Honoured only in IDLE with `start`=0; the register updates at the next edge.
- Both asserted together writes HI and LO.
- Ignored when `busy`, in DONE, or when `start`=1 in the same cycle (`start` wins).

HI/LO hold:
- HI/LO are stable during RUN and retain their old values until DONE.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, `start` at edge 0 -> `busy` cycles 1..32, `done` cycle 33, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then MULT 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100 b=7 -> lo=14, hi=2.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=7 b=0 -> lo=0xFFFFFFFF, hi=7, `done` still at cycle 33.
- During a MULTU: `start` pulse plus new operands at cycle 5, and `mthi` with wdata=0xDEAD at cycle 6 -> both ignored; single `done` at cycle 33 carries the original result. Separately, `reset` low at cycle 10 -> `busy`=0, hi=lo=0 immediately, no `done`.
- IDLE: `mtlo` with wdata=0x00001234 -> lo=0x1234 next cycle, hi unchanged. `mthi` together with `start` -> hi not written, operation launches.
